ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It is the send side paired with the existing `ps2_keyboard` receiver. It takes one command byte per handshake, for example `0xED` (set LEDs) or `0xFF` (reset), and sends it to the keyboard using the PS/2 host request-to-send sequence. It drives the open-drain `ps2_clk`/`ps2_data` pads only through active-high pull-low enables. It reports completion or error with one-cycle pulses, and sits beside `ps2_keyboard` under `top`, sharing the same pads.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: `clk` cycles that `ps2_clk` is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles between consecutive device falling edges before the transfer is aborted (15 ms).

Ports:
- `clk`, in, 1: system clock; one clock domain.
- `clrn`, in, 1: reset, asynchronous, active-low.
- `ps2_clk`, in, 1: pad level of the PS/2 clock (asynchronous).
- `ps2_data`, in, 1: pad level of the PS/2 data (asynchronous).
- `tx_data`, in, 8: command byte.
- `tx_valid`, in, 1: byte offered.
- `tx_ready`, out, 1: transmitter idle; accepts a byte.
- `ps2_clk_oe`, out, 1: 1 pulls `ps2_clk` low; 0 releases it.
- `ps2_data_oe`, out, 1: 1 pulls `ps2_data` low; 0 releases it.
- `done`, out, 1: one-cycle pulse when the device acknowledges.
- `err`, out, 1: one-cycle pulse on missing ACK or timeout.

## Operation
- Reset values: `tx_ready`=1, `ps2_clk_oe`=0, `ps2_data_oe`=0, `done`=0, `err`=0. State is IDLE.
- Asserting `clrn` mid-transfer releases both pads immediately and asynchronously. No pulse is emitted.
- Pad inputs pass through a 3-flop synchronizer. A device falling edge ("fall") is detected when sync stage 2 is 0 and stage 3 is 1.
- Accept: when `tx_valid && tx_ready` in IDLE, the block latches `tx_data` and computes odd parity as `~^tx_data`. `tx_valid` outside IDLE is ignored.
- IDLE → INHIBIT: `clk_oe`=1, `data_oe`=0, held for exactly `INHIBIT_CYCLES` cycles.
- INHIBIT → REQ: one cycle with `clk_oe`=1 and `data_oe`=1 (start bit 0).
- REQ → SEND: `clk_oe`=0 and `data_oe`=1. A bit counter k is cleared to 0.
- SEND: each fall increments k.
  - k=1..8: `data_oe` = `~byte[k-1]` (LSB first).
  - k=9: `data_oe` = `~parity`.
  - k=10: `data_oe`=0 (stop bit). Go to ACK.
- ACK: on the next fall, sample synchronized `ps2_data`.
  - 0: pulse `done` and go to IDLE.
  - 1: pulse `err` and go to IDLE.
- Timeout: the watchdog is active in SEND and ACK. It is cleared on entry to SEND and on every fall. If it reaches `TIMEOUT_CYCLES`, both pads are released, `err` pulses, and the state returns to IDLE.
- `done` and `err` never assert in the same cycle.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- If accept happens in cycle T:
  - `tx_ready`=0 and `clk_oe`=1 from T+1.
  - REQ occupies cycle T+1+`INHIBIT_CYCLES`.
  - `clk_oe` falls in the following cycle.
- `data_oe` updates in the cycle after a fall is detected. That is 3–4 `clk` cycles after the pad edge, well inside the device's half-period of 30 µs or more.
- `tx_ready` returns to 1 in the same cycle that `done`/`err` pulses. A new byte may be accepted in that cycle.
- Minimum transfer length is `INHIBIT_CYCLES` + 1 + 11 device clocks.

## Structure
- Package `ps2_pkg` contains:
  - the state enum `{IDLE, INHIBIT, REQ, SEND, ACK}`;
  - `PS2_NBITS`=8;
  - `PS2_STOP_IDX`=10.
- Sub-module `ps2_sync_edge` contains the 3-flop synchronizer and fall detector. It outputs the synced level and a `fall` pulse, and can be reused by the receiver.
- Remaining RTL: FSM, shift/parity logic, inhibit counter, watchdog.

## Test plan
- Send `0xED` with a device model that ACKs → bits after falls 1–8 are 1,0,1,1,0,1,1,1; parity 1; stop released; `done` pulses once and `err` stays 0.
- Send `0x01` and then `0xFF` back-to-back, with `tx_valid` held → parity 0 then 1; second byte accepted on the `done` cycle; inhibit lasts exactly `INHIBIT_CYCLES` (checked with `INHIBIT_CYCLES`=10).
- Device model leaves `ps2_data` high at the 11th fall → `err` pulses, `done` stays 0, both OEs are 0 the next cycle.
- Device never clocks after REQ (`TIMEOUT_CYCLES`=100) → `err` exactly 100 cycles after entering SEND; pads released.
- `clrn` pulsed low after fall 5 → both OEs drop without waiting for a clock edge, `tx_ready`=1, no `done`/`err`; a following `0x55` completes normally.
- `tx_valid` pulsed with `0xAA` during SEND → ignored; the transmitted byte remains the original.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry
// and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK
    } ps2_state_e;

    localparam int PS2_NBITS    = 8;
    localparam int PS2_STOP_IDX = 10;

    function automatic logic odd_parity(input logic [PS2_NBITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop pad synchronizer with falling-edge detector.
// Reusable by both the PS/2 receiver and transmitter.
module ps2_sync_edge (
    input  logic clk,
    input  logic clrn,
    input  logic pad,
    output logic level,
    output logic fall
);

    // Reset high so an idle bus never looks like a falling edge.
    logic [2:0] sync;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync <= 3'b111;
        end else begin
            sync <= {sync[1:0], pad};
        end
    end

    assign level = sync[1];
    assign fall  = ~sync[1] & sync[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// 11-bit frame clocked by the device, ACK check and watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int KW = $clog2(PS2_STOP_IDX + 1);

    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(PS2_STOP_IDX - 1);
    localparam logic [KW-1:0] K_NBITS   = KW'(PS2_NBITS);
    localparam logic [KW-1:0] K_PARITY  = KW'(PS2_NBITS + 1);

    ps2_state_e state, state_n;

    logic [PS2_NBITS-1:0] byte_q;
    logic                 par_q;
    logic [KW-1:0]        k, k_n;
    logic [IW-1:0]        icnt, icnt_n;
    logic [TW-1:0]        wd, wd_n;
    logic                 load;
    logic                 clk_oe_n, data_oe_n, done_n, err_n;
    logic [PS2_NBITS-1:0] sh;

    logic clk_fall, data_lvl;
    logic unused_clk_lvl, unused_data_fall;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .clrn  (clrn),
        .pad   (ps2_clk),
        .level (unused_clk_lvl),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .clrn  (clrn),
        .pad   (ps2_data),
        .level (data_lvl),
        .fall  (unused_data_fall)
    );

    assign tx_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        k_n     = k;
        icnt_n  = icnt;
        wd_n    = wd;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    load    = 1'b1;
                    icnt_n  = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (icnt == INH_LAST) state_n = REQ;
                else                  icnt_n  = icnt + 1'b1;
            end
            REQ: begin
                state_n = SEND;
                k_n     = '0;
                wd_n    = '0;
            end
            SEND, ACK: begin
                if (clk_fall) begin
                    wd_n = '0;
                    if (state == ACK) begin
                        done_n  = ~data_lvl;
                        err_n   = data_lvl;
                        state_n = IDLE;
                    end else begin
                        k_n = k + 1'b1;
                        if (k == K_LAST) state_n = ACK;
                    end
                end else if (wd == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pad enables are registered from the next state so they never glitch.
    always_comb begin
        sh        = byte_q >> (k_n - KW'(1));
        clk_oe_n  = (state_n == INHIBIT) || (state_n == REQ);
        data_oe_n = 1'b0;
        unique case (1'b1)
            state_n == REQ:
                data_oe_n = 1'b1;
            state_n == SEND && k_n == '0:
                data_oe_n = 1'b1;
            state_n == SEND && k_n != '0 && k_n <= K_NBITS:
                data_oe_n = ~sh[0];
            state_n == SEND && k_n == K_PARITY:
                data_oe_n = ~par_q;
            default:
                data_oe_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            k           <= '0;
            icnt        <= '0;
            wd          <= '0;
            byte_q      <= '0;
            par_q       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            k           <= k_n;
            icnt        <= icnt_n;
            wd          <= wd_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            err         <= err_n;
            if (load) begin
                byte_q <= tx_data;
                par_q  <= odd_parity(tx_data);
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device
// that clocks frames, records host bits and ACKs on request.
module tb_ps2_host_tx;

    localparam int INH = 10;
    localparam int TO  = 100;
    localparam int H   = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    wire        ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    wire        ps2_data = ~(ps2_data_oe | dev_data_low);

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    bit          dev_en = 1'b1;
    bit          dev_ack = 1'b1;
    int          dev_abort = 0;
    int          dev_falls = 0;
    logic [10:0] dev_q[$];

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
    end

    // Device: answers a request-to-send with 11 clocks, sampling the
    // data line late in each high phase. Frame bit 0 is the start bit.
    initial begin
        logic [10:0] frame;
        bit aborted;
        forever begin
            @(negedge clk);
            if (dev_en && clrn && ps2_clk === 1'b1 && ps2_data === 1'b0) begin
                frame = '0;
                aborted = 1'b0;
                dev_falls = 0;
                repeat (H) @(negedge clk);
                frame[0] = ps2_data;
                for (int i = 1; i <= 11; i++) begin
                    if (i == 11 && dev_ack) begin
                        dev_data_low = 1'b1;
                        repeat (2) @(negedge clk);
                    end
                    dev_clk_low = 1'b1;
                    dev_falls = i;
                    repeat (H) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (H) @(negedge clk);
                    dev_data_low = 1'b0;
                    if (i <= 10) frame[i] = ps2_data;
                    if (dev_abort == i) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) dev_q.push_back(frame);
            end
        end
    end

    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9] = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Entered at the negedge of the first cycle after accept.
    task automatic check_request(input string tag);
        int n = 0;
        checks++;
        if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin
            failures++;
            $display("FAIL %s_start ready=%b clk_oe=%b required ready=0 clk_oe=1",
                     tag, tx_ready, ps2_clk_oe);
        end
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 10 * INH) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != INH) begin
            failures++;
            $display("FAIL %s_inhibit cycles=%0d required=%0d", tag, n, INH);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            failures++;
            $display("FAIL %s_req oe=%b required=11", tag, {ps2_clk_oe, ps2_data_oe});
        end
        @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
            failures++;
            $display("FAIL %s_send_entry oe=%b required=01", tag, {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic wait_end(input string tag, input bit exp_done);
        int n = 0;
        logic [1:0] want;
        want = exp_done ? 2'b10 : 2'b01;
        while (done !== 1'b1 && err !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({done, err} !== want) begin
            failures++;
            $display("FAIL %s_end done_err=%b required=%b", tag, {done, err}, want);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b);
        int n = 0;
        logic [10:0] got;
        while (dev_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dev_q.size() == 0) begin
            failures++;
            $display("FAIL %s_frame got=none required=%b", tag, ref_frame(b));
        end else begin
            got = dev_q.pop_front();
            if (got !== ref_frame(b)) begin
                failures++;
                $display("FAIL %s_frame got=%b required=%b", tag, got, ref_frame(b));
            end
        end
    endtask

    task automatic xfer(input string tag, input logic [7:0] b,
                        input bit ack, input bit inject);
        int d0, e0;
        dev_ack = ack;
        wait_ready();
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_request(tag);
        if (inject) begin
            repeat (40) @(negedge clk);
            tx_data = 8'hAA;
            tx_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (tx_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy ready=%b required=0", tag, tx_ready);
            end
            tx_valid = 1'b0;
        end
        wait_end(tag, ack);
        @(negedge clk);
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            failures++;
            $display("FAIL %s_release oe=%b required=00", tag, {ps2_clk_oe, ps2_data_oe});
        end
        checks++;
        if (done_cnt - d0 != int'(ack) || err_cnt - e0 != int'(!ack)) begin
            failures++;
            $display("FAIL %s_pulses done=%0d err=%0d required done=%0d err=%0d",
                     tag, done_cnt - d0, err_cnt - e0, int'(ack), int'(!ack));
        end
        check_frame(tag, b);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=10000",
                     {tx_ready, ps2_clk_oe, ps2_data_oe, done, err});
        end
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_ready, ps2_clk_oe, ps2_data_oe, done, err} !== 5'b10000) begin
            failures++;
            $display("FAIL idle_outputs got=%b required=10000",
                     {tx_ready, ps2_clk_oe, ps2_data_oe, done, err});
        end
    endtask

    task automatic test_set_leds();
        xfer("ed", 8'hED, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit ack;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            xfer("rand", b, ack, 1'b0);
        end
    endtask

    task automatic test_nack();
        xfer("nack", 8'hA5, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_valid();
        xfer("ignore", 8'h3C, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        dev_ack = 1'b1;
        wait_ready();
        @(negedge clk);
        tx_data = 8'h01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        check_request("b2b1");
        wait_end("b2b1", 1'b1);
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_on_done ready=%b required=1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check_request("b2b2");
        wait_end("b2b2", 1'b1);
        check_frame("b2b1", 8'h01);
        check_frame("b2b2", 8'hFF);
    endtask

    task automatic test_timeout();
        int n = 0;
        int e0, d0;
        dev_en = 1'b0;
        wait_ready();
        e0 = err_cnt;
        d0 = done_cnt;
        @(negedge clk);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_request("tmo");
        while (err !== 1'b1 && n < 10 * TO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TO) begin
            failures++;
            $display("FAIL tmo_latency cycles=%0d required=%0d", n, TO);
        end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            failures++;
            $display("FAIL tmo_release oe_ready=%b required=001",
                     {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
        @(negedge clk);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            failures++;
            $display("FAIL tmo_pulses err=%0d done=%0d required err=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        dev_en = 1'b1;
    endtask

    task automatic test_abort();
        int n = 0;
        int e0, d0;
        dev_abort = 5;
        dev_ack = 1'b1;
        wait_ready();
        @(negedge clk);
        tx_data = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_request("abort");
        while (dev_falls != 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (ps2_data_oe !== 1'b1) begin
            failures++;
            $display("FAIL abort_bit4 data_oe=%b required=1", ps2_data_oe);
        end
        e0 = err_cnt;
        d0 = done_cnt;
        #2;
        clrn = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            failures++;
            $display("FAIL abort_async oe_ready=%b required=001",
                     {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
        @(negedge clk);
        clrn = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (err_cnt != e0 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_pulses err=%0d done=%0d required none",
                     err_cnt - e0, done_cnt - d0);
        end
        dev_abort = 0;
        xfer("after_abort", 8'h55, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_abort();
        test_ignore_valid();
        test_random();
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL done_err_overlap cycles=%0d required=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
